// File: rtl/fp_pkg.sv
// Shared floating-point definitions for normalize_round: FSM states, default
// widths, the all-ones exponent and the packed single-precision result layout.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int EXP_MAX   = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } nr_state_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exponent;
    logic [MAN_W_DEF-1:0] fraction;
  } fp32_t;

endpackage

// File: rtl/lzc24.sv
// Leading-zero count of a 24-bit vector (24 when the vector is all zero).
// Compiled only when FAST_NORM_EN is defined; the iterative build has no use for it.
`ifdef FAST_NORM_EN
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) count_o = 5'(23 - i);
    end
  end

endmodule
`endif

// File: rtl/normalize_round.sv
// Post-add normalizer and round-to-nearest-even stage producing a packed float.
// Define FAST_NORM_EN to collapse the one-bit-per-cycle left shift into a single cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for an operand (in_ready high once out of reset)
// ST_NORM  | zero detect, carry shift-right, or left-shift / underflow flush
// ST_ROUND | RNE increment, carry re-normalize, overflow to infinity
// ST_OUT   | result and flags held until out_ready
module normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exponent,
  input  logic [MAN_W+1:0]     in_mantissa,
  input  logic                 in_guard,
  input  logic                 in_round,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_inexact
);

  localparam int MW = MAN_W + 2;
  localparam int XW = EXP_W + 1;

  nr_state_e            state_q, state_d;
  logic                 init_q;
  logic                 sign_q, sign_d;
  logic [XW-1:0]        exp_q, exp_d;
  logic [MW-1:0]        mant_q, mant_d;
  logic                 g_q, g_d, r_q, r_d, s_q, s_d;
  logic [EXP_W+MAN_W:0] res_q, res_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic                 is_zero;
  logic                 inc;
  logic [MW-1:0]        rnd_sum;
  logic [XW-1:0]        rnd_exp;
  logic [MAN_W-1:0]     rnd_frac;

`ifdef FAST_NORM_EN
  logic [4:0]           lz24;
  logic [4:0]           need;
  logic                 vec_nz;
  logic [MAN_W+2:0]     vec, vec_sh;

  lzc24 u_lzc (
    .data_i  (mant_q[MAN_W:0]),
    .count_o (lz24)
  );

  // Shift distance over {mantissa, G, R}, since G and R migrate into the mantissa.
  always_comb begin
    vec    = {mant_q[MAN_W:0], g_q, r_q};
    vec_nz = |vec;
    if (|mant_q[MAN_W:0]) need = lz24;
    else if (g_q)         need = 5'd24;
    else                  need = 5'd25;
    vec_sh = vec << need;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;

    is_zero  = (mant_q == '0) && !(g_q | r_q | s_q);
    inc      = g_q && (r_q || s_q || mant_q[0]);
    rnd_sum  = {1'b0, mant_q[MAN_W:0]} + MW'(inc);
    rnd_exp  = rnd_sum[MAN_W+1] ? exp_q + XW'(1) : exp_q;
    rnd_frac = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exponent};
          mant_d  = in_mantissa;
          g_d     = in_guard;
          r_d     = in_round;
          s_d     = in_sticky;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (is_zero) begin
          res_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = ST_OUT;
        end else if (mant_q[MAN_W+1]) begin
          mant_d  = {1'b0, mant_q[MAN_W+1:1]};
          s_d     = s_q | r_q;
          r_d     = g_q;
          g_d     = mant_q[0];
          exp_d   = exp_q + XW'(1);
          state_d = ST_ROUND;
        end else if (mant_q[MAN_W]) begin
          state_d = ST_ROUND;
`ifdef FAST_NORM_EN
        end else if (vec_nz && (exp_q > XW'(need))) begin
          mant_d  = {1'b0, vec_sh[MAN_W+2:2]};
          g_d     = vec_sh[1];
          r_d     = vec_sh[0];
          exp_d   = exp_q - XW'(need);
          state_d = ST_ROUND;
        end else begin
`else
        end else if (exp_q <= XW'(1)) begin
`endif
          res_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          inx_d   = |{mant_q, g_q, r_q, s_q};
          state_d = ST_OUT;
`ifndef FAST_NORM_EN
        end else begin
          mant_d  = {mant_q[MAN_W:0], g_q};
          g_d     = r_q;
          r_d     = 1'b0;
          exp_d   = exp_q - XW'(1);
`endif
        end
      end
      ST_ROUND: begin
        inx_d = g_q | r_q | s_q;
        unf_d = 1'b0;
        if (rnd_exp >= XW'(EXP_MAX)) begin
          res_d = {sign_q, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          res_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          ovf_d = 1'b0;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = init_q && (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
  end

  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: carry, cancellation, RNE ties, overflow,
// zero, underflow flush, backpressure hold and mid-operation reset.
module tb_normalize_round;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
`ifdef FAST_NORM_EN
  localparam int LAT_CANC = 3;
`else
  localparam int LAT_CANC = 4;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [EXP_W-1:0]  in_exponent = '0;
  logic [MAN_W+1:0]  in_mantissa = '0;
  logic              in_guard = 1'b0;
  logic              in_round = 1'b0;
  logic              in_sticky = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [EXP_W+MAN_W:0] out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;

  int checks = 0;
  int errors = 0;
  int lat;
  int stale;

  normalize_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_mantissa   (in_mantissa),
    .in_guard      (in_guard),
    .in_round      (in_round),
    .in_sticky     (in_sticky),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res,
                         input logic ovf, input logic unf, input logic inx);
    chk($sformatf("%s_valid", tag), 64'(out_valid), 64'd1);
    chk($sformatf("%s_result", tag), 64'(out_result), 64'(res));
    chk($sformatf("%s_ovf", tag), 64'(out_overflow), 64'(ovf));
    chk($sformatf("%s_unf", tag), 64'(out_underflow), 64'(unf));
    chk($sformatf("%s_inx", tag), 64'(out_inexact), 64'(inx));
  endtask

  // Accept on the next edge, then count cycles until out_valid (accept cycle = 0).
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                      input logic g, input logic r, input logic st);
    chk("send_ready", 64'(in_ready), 64'd1);
    in_sign = s; in_exponent = e; in_mantissa = m;
    in_guard = g; in_round = r; in_sticky = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_ready_post", 64'(in_ready), 64'd1);

    send(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0);
    chk("carry_lat", 64'(lat), 64'd3);
    chk_out("carry", 32'h40000000, 1'b0, 1'b0, 1'b0);
    drain();

    send(1'b0, 8'd127, 25'h0400000, 1'b0, 1'b0, 1'b0);
    chk("canc_lat", 64'(lat), 64'(LAT_CANC));
    chk_out("canc", 32'h3F000000, 1'b0, 1'b0, 1'b0);
    drain();

    send(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0);
    chk_out("tie_odd", 32'h3F800002, 1'b0, 1'b0, 1'b1);
    drain();

    send(1'b0, 8'd127, 25'h0800000, 1'b1, 1'b0, 1'b0);
    chk_out("tie_even", 32'h3F800000, 1'b0, 1'b0, 1'b1);
    drain();

    send(1'b0, 8'd254, 25'h0FFFFFF, 1'b1, 1'b1, 1'b0);
    chk_out("rnd_ovf", 32'h7F800000, 1'b1, 1'b0, 1'b1);
    drain();

    send(1'b1, 8'd100, 25'h0000000, 1'b0, 1'b0, 1'b0);
    chk("zero_lat", 64'(lat), 64'd2);
    chk_out("neg_zero", 32'h80000000, 1'b0, 1'b0, 1'b0);
    drain();

    // Three is too small an exponent to bring bit 0 up to the implicit-one position.
    send(1'b0, 8'd3, 25'h0000001, 1'b0, 1'b0, 1'b0);
    chk_out("uflow", 32'h00000000, 1'b0, 1'b1, 1'b1);
    drain();

    send(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0);
    chk_out("bp_first", 32'h3F800002, 1'b0, 1'b0, 1'b1);
    in_mantissa = 25'h1000000; in_exponent = 8'd10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'h3F800002);
      chk("bp_inexact", 64'(out_inexact), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    drain();

    in_sign = 1'b1; in_exponent = 8'd127; in_mantissa = 25'h0000010;
    in_guard = 1'b0; in_round = 1'b0; in_sticky = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    chk("mid_rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);
    chk("mid_idle_ready", 64'(in_ready), 64'd1);

    send(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0);
    chk("post_lat", 64'(lat), 64'd3);
    chk_out("post", 32'h40000000, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
